ped_request_unit: RTL and testbench
===================================

// Module: ped_request_unit
// PURPOSE
//  Front end for the pedestrian push-buttons of the four-way junction.
//  - Synchronises and debounces each button, then latches a press as a level request p_e[i].
//  - Holds p_e[i] until the traffic controller grants walk[i] (its P1..P4 outputs).
//  - Drives a per-crossing "wait" lamp that blinks when the wait time is exceeded.
// PARAMETERS
//  N_CH          4         number of crossings (bit i = crossing i+1)
//  DEBOUNCE_CYC  500000    consecutive clk cycles a new button level must hold (10 ms @ 50 MHz)
//  TICK_DIV      50000000  clk cycles per 1 s wait-timer tick
//  WAIT_W        8         width of each per-channel wait-seconds counter
//  MAX_WAIT_S    60        wait seconds after which overdue[i] asserts
// PORTS
//  clk      in   1      system clock
//  rst_n    in   1      asynchronous active-low reset
//  btn      in   N_CH   raw, asynchronous push-button levels (1 = pressed)
//  walk     in   N_CH   walk grant from traffic controller (P1..P4), synchronous to clk
//  p_e      out  N_CH   registered pedestrian request level to traffic controller
//  pending  out  N_CH   wait lamp: steady 1 while waiting, blinks at 1 tick rate when overdue
//  overdue  out  N_CH   1 while waiting and wait_s >= MAX_WAIT_S
// BEHAVIOUR
//  Reset
//  - rst_n=0 asynchronously clears all flops: p_e, pending, overdue = 0.
//  - Also clears sync/debounce state (stable level = 0), wait counters, prescaler and blink toggle.
//  - All channels go to IDLE. Reset mid-request discards the request.
//  Input path (per channel)
//  - 2-flop synchroniser on btn[i].
//  - Debounce counter counts while the synced level != stable level and resets to 0 when they are equal.
//  - On reaching DEBOUNCE_CYC, stable takes the synced level and the counter clears.
//  - press[i] = stable & ~stable_q (one-cycle pulse on the debounced rising edge).
//  Latency
//  - btn held high from the edge that first samples it: p_e[i] visible after exactly DEBOUNCE_CYC+3 edges.
//  - Any bounce shorter than DEBOUNCE_CYC produces nothing.
//  Per-channel FSM (IDLE, REQ, WALK)
//  - IDLE: walk[i]=1 -> WALK; else press[i] -> REQ.
//  - REQ: walk[i]=1 -> WALK; otherwise stay. p_e[i]=1 only in REQ.
//  - WALK: walk[i]=0 -> IDLE. Presses are ignored; the pedestrian is already being served.
//  - Simultaneous press and walk in IDLE: walk wins -> WALK, press discarded.
//  - p_e[i] deasserts on the edge after walk[i] is sampled high (1-cycle grant-to-drop latency).
//  - Controller samples slowly, so p_e is a level, never a pulse.
//  Wait timer
//  - Shared prescaler 0..TICK_DIV-1 wraps and issues a 1-cycle tick at TICK_DIV-1.
//  - Blink toggle flips on each tick.
//  - wait_s[i] clears on entry to REQ and increments on tick while in REQ.
//  - wait_s[i] saturates at 2^WAIT_W-1 (no wrap) and is held (don't care) outside REQ.
//  - Tick on the entry cycle is not counted.
//  Lamp outputs (registered)
//  - overdue[i] = (state==REQ) && (wait_s[i] >= MAX_WAIT_S).
//  - pending[i] = REQ ? (overdue ? blink : 1) : 0.
//  - All outputs are registered, so there are no glitches towards the lamp drivers.
// STRUCTURE
//  - Shared package ped_pkg holds: FSM state encodings (IDLE=2'd0, REQ=2'd1, WALK=2'd2) and default timing constants.
//  - The same package also holds the lamp codes (RED=3'b100, YEL=3'b010, GRN=3'b001) for use across the junction blocks.
//  - Sub-module ped_debounce: synchroniser + debounce counter + rising-edge pulse, one instance per channel via generate.
//  - Top-level file contains the prescaler, per-channel FSMs, wait counters and output registers.
// TESTING (bench params: DEBOUNCE_CYC=4, TICK_DIV=10, MAX_WAIT_S=3, WAIT_W=2)
//  1. rst_n=0 with btn=4'hF, walk=0 -> p_e, pending, overdue = 0; after release, still 0 until a debounced press occurs.
//  2. btn[1]=1 held 12 cycles -> p_e[1] rises exactly 7 edges after first sample; pending[1]=1; other bits 0.
//  3. btn[0] pulses 1 for 3 cycles, then 0 -> p_e[0] stays 0 indefinitely.
//  4. In REQ, set walk[1]=1 -> p_e[1]=0 next edge.
//     Press btn[1] again during walk -> no effect.
//     walk[1]=0 -> IDLE with p_e[1]=0.
//  5. REQ held with walk=0 for 40 cycles -> overdue[1]=1 after the 3rd tick.
//     pending[1] toggles every 10 cycles; wait_s saturates at 3 without wrap.
//  6. Debounced press and walk[2] rise on the same cycle -> p_e[2] never asserts.
//     rst_n=0 mid-REQ on ch3 -> p_e[3]=0 immediately.

Source files
------------

// File: rtl/ped_pkg.sv
// Shared junction definitions: pedestrian FSM states, lamp codes and default timing.
// Pure declarations; no logic, no latency.
package ped_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WALK = 2'd2
    } ped_state_e;

    typedef enum logic [2:0] {
        LAMP_GRN = 3'b001,
        LAMP_YEL = 3'b010,
        LAMP_RED = 3'b100
    } lamp_e;

    // 50 MHz system clock: 10 ms debounce, 1 s wait tick, 60 s patience.
    localparam int N_CH_DEF         = 4;
    localparam int DEBOUNCE_CYC_DEF = 500000;
    localparam int TICK_DIV_DEF     = 50000000;
    localparam int WAIT_W_DEF       = 8;
    localparam int MAX_WAIT_S_DEF   = 60;

    function automatic int cnt_width(input int max_count);
        return (max_count > 1) ? $clog2(max_count) : 1;
    endfunction

endpackage

// File: rtl/ped_debounce.sv
// One push-button: 2-flop synchroniser, debounce counter, one-cycle pulse on debounced rise.
// Pulse appears DEBOUNCE_CYC+2 edges after the first sampling edge; no backpressure.
module ped_debounce
    import ped_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic press_o
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stable_q, stable_d;
    logic             stable_dly_q;

    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (sync_q[1] == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d    = '0;
            stable_d = sync_q[1];
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q       <= '0;
            cnt_q        <= '0;
            stable_q     <= 1'b0;
            stable_dly_q <= 1'b0;
        end else begin
            sync_q       <= {sync_q[0], btn_i};
            cnt_q        <= cnt_d;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
        end
    end

    assign press_o = stable_q & ~stable_dly_q;

endmodule

// File: rtl/ped_request_unit.sv
// Pedestrian push-button front end: debounced press latched as a level request until walk grant.
// Request visible DEBOUNCE_CYC+3 edges after button sampled; drops 1 edge after walk; no backpressure.
module ped_request_unit
    import ped_pkg::*;
#(
    parameter int N_CH         = N_CH_DEF,
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
    parameter int TICK_DIV     = TICK_DIV_DEF,
    parameter int WAIT_W       = WAIT_W_DEF,
    parameter int MAX_WAIT_S   = MAX_WAIT_S_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] btn,
    input  logic [N_CH-1:0] walk,
    output logic [N_CH-1:0] p_e,
    output logic [N_CH-1:0] pending,
    output logic [N_CH-1:0] overdue
);

    localparam int PRESC_W = cnt_width(TICK_DIV);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic               tick;
    logic               blink_q, blink_d;
    logic [N_CH-1:0]    press;

    assign tick    = (presc_q == PRESC_LAST);
    assign presc_d = tick ? '0 : presc_q + 1'b1;
    assign blink_d = blink_q ^ tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            blink_q <= 1'b0;
        end else begin
            presc_q <= presc_d;
            blink_q <= blink_d;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        ped_state_e        state_q, state_d;
        logic [WAIT_W-1:0] wait_q, wait_d;
        logic              p_e_q, pending_q, overdue_q;
        logic              in_req_d, overdue_d, pending_d;

        ped_debounce #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC)
        ) u_debounce (
            .clk     (clk),
            .rst_n   (rst_n),
            .btn_i   (btn[i]),
            .press_o (press[i])
        );

        // Walk has priority over a coincident press: the pedestrian is served already.
        always_comb begin
            state_d = state_q;
            wait_d  = wait_q;
            case (state_q)
                ST_IDLE: begin
                    if (walk[i]) begin
                        state_d = ST_WALK;
                    end else if (press[i]) begin
                        state_d = ST_REQ;
                        wait_d  = '0;
                    end
                end
                ST_REQ: begin
                    if (walk[i]) begin
                        state_d = ST_WALK;
                    end else if (tick && (wait_q != {WAIT_W{1'b1}})) begin
                        wait_d = wait_q + 1'b1;
                    end
                end
                ST_WALK: begin
                    if (!walk[i]) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        assign in_req_d  = (state_d == ST_REQ);
        assign overdue_d = in_req_d && (32'(wait_d) >= MAX_WAIT_S);
        assign pending_d = in_req_d && (overdue_d ? blink_d : 1'b1);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q   <= ST_IDLE;
                wait_q    <= '0;
                p_e_q     <= 1'b0;
                pending_q <= 1'b0;
                overdue_q <= 1'b0;
            end else begin
                state_q   <= state_d;
                wait_q    <= wait_d;
                p_e_q     <= in_req_d;
                pending_q <= pending_d;
                overdue_q <= overdue_d;
            end
        end

        assign p_e[i]     = p_e_q;
        assign pending[i] = pending_q;
        assign overdue[i] = overdue_q;
    end

endmodule

// File: tb/tb_ped_request_unit.sv
// Directed bench for ped_request_unit with short debounce and tick periods.
module tb_ped_request_unit;

    localparam int DEB = 4;
    localparam int TD  = 10;
    localparam int MW  = 3;
    localparam int WW  = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] btn, walk, p_e, pending, overdue;

    int n_tests = 0;
    int n_fail  = 0;
    int ecnt;

    always #5 clk = ~clk;

    ped_request_unit #(
        .N_CH         (4),
        .DEBOUNCE_CYC (DEB),
        .TICK_DIV     (TD),
        .WAIT_W       (WW),
        .MAX_WAIT_S   (MW)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn     (btn),
        .walk    (walk),
        .p_e     (p_e),
        .pending (pending),
        .overdue (overdue)
    );

    // Edges since reset release; a prescaler tick lands on every TD-th edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ecnt <= 0;
        else        ecnt <= ecnt + 1;
    end

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int         ticks;
        logic       bl;
        logic [3:0] exp_ov, exp_pd;

        rst_n = 1'b0;
        btn   = 4'hF;
        walk  = 4'h0;
        #12;
        chk("rst_pe", p_e, 4'h0);
        chk("rst_pending", pending, 4'h0);
        chk("rst_overdue", overdue, 4'h0);
        step(3);
        btn = 4'h0;
        step(1);
        rst_n = 1'b1;
        step(10);
        chk("idle_after_rst", p_e, 4'h0);

        btn[1] = 1'b1;
        step(DEB + 2);
        chk("press_lat_early", p_e, 4'h0);
        step(1);
        chk("press_lat_exact", p_e, 4'b0010);
        chk("press_pending", pending, 4'b0010);
        chk("press_overdue", overdue, 4'h0);
        step(5);
        btn[1] = 1'b0;
        step(10);
        chk("req_held", p_e, 4'b0010);

        btn[0] = 1'b1;
        step(3);
        btn[0] = 1'b0;
        step(20);
        chk("bounce_ignored", p_e, 4'b0010);

        walk[1] = 1'b1;
        step(1);
        chk("grant_drop", p_e, 4'h0);
        chk("grant_pending", pending, 4'h0);
        btn[1] = 1'b1;
        step(12);
        btn[1] = 1'b0;
        chk("press_in_walk", p_e, 4'h0);
        step(10);
        walk[1] = 1'b0;
        step(1);
        chk("walk_release", p_e, 4'h0);
        step(10);
        chk("back_idle", p_e, 4'h0);

        btn[1] = 1'b1;
        step(DEB + 3);
        chk("repress", p_e, 4'b0010);
        btn[1] = 1'b0;
        ticks = 0;
        for (int c = 0; c < 40; c++) begin
            step(1);
            if (ecnt % TD == 0) ticks++;
            bl     = ((ecnt / TD) % 2) == 1;
            exp_ov = (ticks >= MW) ? 4'b0010 : 4'b0000;
            exp_pd = (ticks >= MW) ? {2'b00, bl, 1'b0} : 4'b0010;
            chk("wait_overdue", overdue, exp_ov);
            chk("wait_pending", pending, exp_pd);
        end
        chk("wait_still_req", p_e, 4'b0010);
        walk[1] = 1'b1;
        step(1);
        chk("overdue_cleared", overdue, 4'h0);
        walk[1] = 1'b0;
        step(2);

        btn[2] = 1'b1;
        step(DEB + 2);
        walk[2] = 1'b1;
        step(1);
        chk("walk_beats_press", p_e, 4'h0);
        step(5);
        btn[2] = 1'b0;
        step(8);
        chk("walk_beats_press_hold", p_e, 4'h0);
        walk[2] = 1'b0;
        step(2);
        chk("walk_beats_press_idle", p_e, 4'h0);

        btn[3] = 1'b1;
        step(DEB + 3);
        chk("ch3_req", p_e, 4'b1000);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_pe", p_e, 4'h0);
        chk("async_rst_pending", pending, 4'h0);
        btn = 4'h0;
        step(2);
        rst_n = 1'b1;
        step(10);
        chk("rst_discards_req", p_e, 4'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
